// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner selection for a shared 8:1 single-bit serial mux.
// Define BURST_LIMIT_EN to cap each ownership at BURST_LEN consecutive cycles.
module mux8_rr_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       y,
  output logic       valid,
  output logic       o_dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;
  logic [2:0] r_sel;
  logic       r_y;
  logic       r_valid;

  logic [2:0] w_base;
  logic [2:0] w_idx;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_cap;
  logic       w_release;
  logic       w_take;
  logic [2:0] w_ptr_nxt;
  logic [7:0] w_gnt_nxt;
  logic [2:0] w_sel_nxt;

  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("BURST_LEN must be in 1..255");
  end

  // The owner itself is the last candidate because the scan starts just past it.
  always_comb begin
    w_base  = (r_state == S_GRANT) ? r_sel + 3'd1 : r_ptr;
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      w_idx = w_base + 3'(i);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

`ifdef BURST_LIMIT_EN
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  assign w_cap = (r_cnt == 8'(BURST_LEN));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_take) begin
      w_cnt_nxt = 8'd1;
    end else if (r_state == S_GRANT && !w_cap) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_cap = 1'b0;
`endif

  assign w_release = (r_state == S_GRANT) && (!req[r_sel] || w_cap);
  assign w_take    = w_found && ((r_state == S_IDLE) || w_release);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_gnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_y     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_y     <= (r_gnt != 8'd0) ? in[r_sel] : 1'b0;
      r_valid <= (r_gnt != 8'd0);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release && !w_found) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next grant, select and pointer
  always_comb begin
    w_gnt_nxt = r_gnt;
    w_sel_nxt = r_sel;
    w_ptr_nxt = r_ptr;
    if (w_release) begin
      w_ptr_nxt = r_sel + 3'd1;
    end
    if (w_take) begin
      w_gnt_nxt = 8'b1 << w_win;
      w_sel_nxt = w_win;
    end else if (w_release) begin
      w_gnt_nxt = 8'd0;
    end
  end

  assign gnt         = r_gnt;
  assign sel         = r_sel;
  assign y           = r_y;
  assign valid       = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed-vector bench for mux8_rr_arbiter (BURST_LEN = 4); covers both
// BURST_LIMIT_EN builds.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       valid;
  logic       dbg_state;

  int n_vec = 0;
  int n_err = 0;

  mux8_rr_arbiter #(.BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .in         (in),
    .gnt        (gnt),
    .sel        (sel),
    .y          (y),
    .valid      (valid),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; in = 8'hFF;
    step();
    step();
    n_vec++; if (gnt !== 8'h00)   begin n_err++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    n_vec++; if (sel !== 3'd0)    begin n_err++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_vec++; if (y !== 1'b0)      begin n_err++; $display("FAIL reset_y got=%b exp=0", y); end
    n_vec++; if (valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    rst = 1'b0;
  endtask

  // Source 3 alone; other data bits are the complement so a wrong select shows on y.
  task automatic test_single_owner();
    logic b;
    req = 8'h08;
    for (int c = 0; c < 10; c++) begin
      b  = (c % 2 == 0);
      in = b ? 8'h08 : 8'hF7;
      step();
      n_vec++; if (gnt !== 8'h08) begin n_err++; $display("FAIL single_gnt c=%0d got=%h exp=08", c, gnt); end
      n_vec++; if (sel !== 3'd3)  begin n_err++; $display("FAIL single_sel c=%0d got=%0d exp=3", c, sel); end
      n_vec++; if (valid !== (c != 0)) begin n_err++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, valid, (c != 0)); end
      n_vec++; if (y !== ((c != 0) ? b : 1'b0)) begin n_err++; $display("FAIL single_y c=%0d got=%b exp=%b", c, y, ((c != 0) ? b : 1'b0)); end
    end
  endtask

  task automatic test_drop_switch();
    in = 8'h40;
    req = 8'h20;
    step();
    n_vec++; if (gnt !== 8'h20) begin n_err++; $display("FAIL drop_own5 got=%h exp=20", gnt); end
    req = 8'h64;
    step();
    n_vec++; if (gnt !== 8'h20) begin n_err++; $display("FAIL drop_hold5 got=%h exp=20", gnt); end
    req = 8'h44;
    step();
    n_vec++; if (gnt !== 8'h40) begin n_err++; $display("FAIL drop_to6 got=%h exp=40", gnt); end
    n_vec++; if (sel !== 3'd6)  begin n_err++; $display("FAIL drop_sel6 got=%0d exp=6", sel); end
    n_vec++; if (y !== 1'b0)    begin n_err++; $display("FAIL drop_y5 got=%b exp=0", y); end
    step();
    n_vec++; if (gnt !== 8'h40) begin n_err++; $display("FAIL drop_hold6 got=%h exp=40", gnt); end
    n_vec++; if (y !== 1'b1)    begin n_err++; $display("FAIL drop_y6 got=%b exp=1", y); end
    req = 8'h04;
    step();
    n_vec++; if (gnt !== 8'h04) begin n_err++; $display("FAIL drop_to2 got=%h exp=04", gnt); end
    n_vec++; if (sel !== 3'd2)  begin n_err++; $display("FAIL drop_sel2 got=%0d exp=2", sel); end
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL drop_valid got=%b exp=1", valid); end
  endtask

  // Pointer is 3 before reset, so only a cleared pointer makes source 1 win afterwards.
  task automatic test_reset_mid_grant();
    in = 8'hFF;
    req = 8'h10;
    step();
    n_vec++; if (gnt !== 8'h10) begin n_err++; $display("FAIL rmid_own4 got=%h exp=10", gnt); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (gnt !== 8'h00)  begin n_err++; $display("FAIL rmid_gnt got=%h exp=00", gnt); end
    n_vec++; if (sel !== 3'd0)   begin n_err++; $display("FAIL rmid_sel got=%0d exp=0", sel); end
    n_vec++; if (y !== 1'b0)     begin n_err++; $display("FAIL rmid_y got=%b exp=0", y); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", valid); end
    req = 8'h12;
    step();
    n_vec++; if (gnt !== 8'h02) begin n_err++; $display("FAIL rmid_regrant got=%h exp=02", gnt); end
    n_vec++; if (sel !== 3'd1)  begin n_err++; $display("FAIL rmid_resel got=%0d exp=1", sel); end
  endtask

  task automatic test_idle_bubble();
    req = 8'h00;
    step();
    n_vec++; if (gnt !== 8'h00)  begin n_err++; $display("FAIL idle_gnt got=%h exp=00", gnt); end
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL idle_valid_lag got=%b exp=1", valid); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL idle_state got=%b exp=0", dbg_state); end
    step();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%b exp=0", valid); end
    n_vec++; if (y !== 1'b0)     begin n_err++; $display("FAIL idle_y got=%b exp=0", y); end
    req = 8'h80;
    step();
    req = 8'h00;
    n_vec++; if (gnt !== 8'h80) begin n_err++; $display("FAIL idle_pulse_gnt got=%h exp=80", gnt); end
    n_vec++; if (sel !== 3'd7)  begin n_err++; $display("FAIL idle_pulse_sel got=%0d exp=7", sel); end
    step();
    n_vec++; if (gnt !== 8'h00) begin n_err++; $display("FAIL idle_after_pulse got=%h exp=00", gnt); end
  endtask

`ifdef BURST_LIMIT_EN
  // Pointer is 0 here (last release was from source 7), so the walk starts at source 0.
  task automatic test_full_rotation();
    logic [7:0] exp_g;
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      exp_g = 8'h01 << ((c / 4) % 8);
      step();
      n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL rot_gnt c=%0d got=%h exp=%h", c, gnt, exp_g); end
      n_vec++; if (sel !== 3'((c / 4) % 8)) begin n_err++; $display("FAIL rot_sel c=%0d got=%0d exp=%0d", c, sel, (c / 4) % 8); end
    end
    req = 8'h00;
    step();
  endtask
`else
  task automatic test_back_to_back();
    req = 8'h12;
    for (int c = 0; c < 20; c++) begin
      step();
      n_vec++; if (gnt !== 8'h02) begin n_err++; $display("FAIL hold1_gnt c=%0d got=%h exp=02", c, gnt); end
    end
    req = 8'h10;
    step();
    n_vec++; if (gnt !== 8'h10) begin n_err++; $display("FAIL hold1_switch got=%h exp=10", gnt); end
    n_vec++; if (sel !== 3'd4)  begin n_err++; $display("FAIL hold1_sel got=%0d exp=4", sel); end
    req = 8'h00;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = 8'h00;
    in  = 8'h00;
    test_reset();
    test_single_owner();
    test_drop_switch();
    test_reset_mid_grant();
    test_idle_bubble();
`ifdef BURST_LIMIT_EN
    test_full_rotation();
`else
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin controller that shares one 8:1 single-bit mux datapath among 8 requesters.
- Per cycle: picks one owner, drives the mux select and a one-hot grant, and registers the selected data bit onto a shared serial output.
- Sits between 8 bit-serial sources and a single downstream serial sink.

Parameters:
- BURST_LEN, 4, maximum consecutive cycles one owner may hold the mux. Used only with BURST_LIMIT_EN. Legal range 1..255.

Ports:
- clk    input   1  rising-edge clock
- rst    input   1  synchronous, active-high reset
- req    input   8  request per source; req[i] high means source i wants the mux
- in     input   8  data bit per source; in[i] belongs to source i
- gnt    output  8  one-hot registered grant; all-zero when idle
- sel    output  3  registered mux select, the binary index of the owner
- y      output  1  registered mux output, equal to in[sel] sampled one cycle earlier
- valid  output 1  y carries owner data

Behaviour:
- Reset (rst=1 at a clk edge), next cycle:
  - gnt=0, sel=0, y=0, valid=0.
  - state=IDLE, rr pointer ptr=0, burst count cnt=0.
  - Reset overrides all other events, including mid-grant.
- Arbitration search: the first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7 (mod 8).
- FSM states: IDLE, GRANT.
- IDLE:
  - gnt=0, no owner.
  - If req!=0 at an edge: GRANT with owner w (search result), gnt=1<<w, sel=w, cnt=1.
  - Otherwise stay in IDLE.
- GRANT with owner k, release condition:
  - req[k]=0, OR
  - with BURST_LIMIT_EN: cnt==BURST_LEN.
  - Both true in the same cycle counts as a single release.
- On release:
  - ptr <= k+1 mod 8.
  - Search from k+1 over req, so k is the last candidate.
  - If a winner w exists: switch to w on that same edge (gnt=1<<w, sel=w, cnt=1), with no idle bubble.
  - If no winner: go to IDLE, gnt=0.
- No release: hold owner, cnt <= cnt+1, saturating at BURST_LEN.
- Data path:
  - Every edge: y <= in[sel_current] when gnt!=0, else y <= 0.
  - valid <= (gnt!=0).
  - y and valid therefore lag gnt/sel by exactly 1 cycle.
- Width rules:
  - cnt is 8 bits.
  - ptr is 3 bits and wraps 7 -> 0 naturally.
- Grant invariant: gnt is always one-hot or zero, and sel==index(gnt) whenever gnt!=0.
- Late requests: a request arriving while another source owns the mux waits for release. It is never served within the owner's burst.

Optional Feature:
- Macro: BURST_LIMIT_EN.
- Defined:
  - Ownership is capped at BURST_LEN consecutive cycles.
  - At the cap, the owner is released even if its req stays high.
  - It is re-granted only after the other pending requesters have been served (or immediately if no other source is pending).
- Undefined:
  - The cnt logic and the BURST_LEN comparison are removed.
  - Ownership lasts until the owner's req drops.
  - BURST_LEN is ignored.

Test Plan:
- Single owner: after reset, req=8'h08 held for 10 cycles, with in[3] toggling 1,0,1,...
  - gnt=8'h08 and sel=3 from the first post-request edge.
  - y equals in[3] delayed 1 cycle; valid=1 from the second edge.
- Full rotation (macro on, BURST_LEN=4): req=8'hFF held.
  - gnt walks 01,02,04,...,80, then back to 01, 4 cycles each.
  - No cycle with gnt=0.
- Drop-driven switch: owner 5 with req[2] and req[6] also pending; req[5] drops.
  - Next edge gnt=8'h40 (source 6).
  - When req[6] drops, gnt=8'h04 (source 2).
- Reset mid-grant: source 4 owns the mux with cnt=2; assert rst for 1 cycle.
  - Next cycle gnt=0, sel=0, y=0, valid=0.
  - With req=8'h12 afterwards, the next grant goes to source 1 (ptr=0).
- Macro off: req[1] held for 20 cycles with req[4] pending throughout.
  - gnt=8'h02 for all 20 cycles, then 8'h10 on the edge after req[1] drops.
- Idle bubble: all req drop.
  - Next edge gnt=0 and valid falls one cycle later.
  - A new req[7] pulse in IDLE gives gnt=8'h80 on the following edge.
